// File: rtl/noc_router_pkg.sv
// Shared router types: arbiter FSM encoding and default channel geometry.
// Pure declarations, no logic.
package noc_router_pkg;

  localparam int NUM_VC_DEF = 4;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vc_sw_arbiter_rr_pick.sv
// Round-robin selector: first requester at or after ptr, ascending with wrap.
// Purely combinational, no backpressure.
module rr_pick
  import noc_router_pkg::*;
#(
  parameter int N = NUM_VC_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] idx;

  // Walk offsets from the far end so the nearest requester to ptr wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_sw_arbiter.sv
// Wormhole VC-to-switch arbiter: 1-cycle grant, then the locked VC streams to out_ready until its tail.
// Optional 16-bit tail-transfer counter port when VC_ARB_PKTCNT_EN is defined.
module vc_sw_arbiter
  import noc_router_pkg::*;
#(
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_VC-1:0]          vc_valid,
  input  logic [NUM_VC*DATA_W-1:0]   vc_data,
  input  logic [NUM_VC-1:0]          vc_head,
  input  logic [NUM_VC-1:0]          vc_tail,
  output logic [NUM_VC-1:0]          vc_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_head,
  output logic                       out_tail,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_VC)-1:0]  out_vc,
  output logic                       err_nohead
`ifdef VC_ARB_PKTCNT_EN
  ,
  output logic [15:0]                pkt_count
`endif
);

  localparam int VW = $clog2(NUM_VC);

  arb_state_t    state, state_nxt;
  logic [VW-1:0] lock_vc, lock_vc_nxt;
  logic [VW-1:0] rr_ptr, rr_ptr_nxt;
  logic [VW-1:0] pick_idx;
  logic          pick_any;
  logic          locked;
  logic          tail_xfer;

  rr_pick #(.N(NUM_VC)) u_rr_pick (
    .req     (vc_valid & vc_head),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  assign locked    = (state == LOCKED);
  assign out_vc    = lock_vc;
  assign tail_xfer = out_valid & out_ready & out_tail;

  // Output mux is zeroed in IDLE so nothing leaks onto the switch between packets.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_head  = 1'b0;
    out_tail  = 1'b0;
    vc_ready  = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (locked && lock_vc == VW'(i)) begin
        out_valid   = vc_valid[i];
        out_data    = vc_data[i*DATA_W +: DATA_W];
        out_head    = vc_head[i];
        out_tail    = vc_tail[i];
        vc_ready[i] = out_ready & vc_valid[i];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    lock_vc_nxt = lock_vc;
    rr_ptr_nxt  = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt   = LOCKED;
          lock_vc_nxt = pick_idx;
        end
      end
      LOCKED: begin
        if (tail_xfer) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (lock_vc == VW'(NUM_VC - 1)) ? '0 : lock_vc + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lock_vc    <= '0;
      rr_ptr     <= '0;
      err_nohead <= 1'b0;
    end else begin
      state      <= state_nxt;
      lock_vc    <= lock_vc_nxt;
      rr_ptr     <= rr_ptr_nxt;
      // A body flit at the head of a VC while idle means a lost head.
      err_nohead <= err_nohead | (~locked & |(vc_valid & ~vc_head));
    end
  end

`ifdef VC_ARB_PKTCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
    end else if (tail_xfer) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_sw_arbiter.sv
// Bench for vc_sw_arbiter: packet-level model plus directed scenarios with literal expectations.
module tb_vc_sw_arbiter;
  import noc_router_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     vc_valid = '0;
  logic [N*W-1:0]   vc_data = '0;
  logic [N-1:0]     vc_head = '0;
  logic [N-1:0]     vc_tail = '0;
  logic [N-1:0]     vc_ready;
  logic [W-1:0]     out_data;
  logic             out_head;
  logic             out_tail;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_vc;
  logic             err_nohead;
`ifdef VC_ARB_PKTCNT_EN
  logic [15:0]      pkt_count;
`endif

  vc_sw_arbiter #(.NUM_VC(N), .DATA_W(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vc_valid   (vc_valid),
    .vc_data    (vc_data),
    .vc_head    (vc_head),
    .vc_tail    (vc_tail),
    .vc_ready   (vc_ready),
    .out_data   (out_data),
    .out_head   (out_head),
    .out_tail   (out_tail),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vc     (out_vc),
    .err_nohead (err_nohead)
`ifdef VC_ARB_PKTCNT_EN
    ,
    .pkt_count  (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Packet-level model: which VC owns the output (-1 = none), where the search starts, error flag.
  int m_lock = -1;
  int m_ptr  = 0;
  bit m_err  = 1'b0;
  int m_pkts = 0;
  int m_cand;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put(input int vc, input bit v, input bit h, input bit t, input logic [31:0] d);
    vc_valid[vc]       = v;
    vc_head[vc]        = h;
    vc_tail[vc]        = t;
    vc_data[vc*W +: W] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lock = -1;
      m_ptr  = 0;
      m_err  = 1'b0;
      m_pkts = 0;
    end else if (m_lock < 0) begin
      for (int v = 0; v < N; v++)
        if (vc_valid[v] && !vc_head[v]) m_err = 1'b1;
      m_cand = -1;
      for (int k = N - 1; k >= 0; k--)
        if (vc_valid[(m_ptr + k) % N] && vc_head[(m_ptr + k) % N]) m_cand = (m_ptr + k) % N;
      m_lock = m_cand;
    end else if (vc_valid[m_lock] && out_ready && vc_tail[m_lock]) begin
      m_pkts = m_pkts + 1;
      m_ptr  = (m_lock + 1) % N;
      m_lock = -1;
    end
  end

  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      automatic bit exp_v = (m_lock >= 0) ? vc_valid[m_lock] : 1'b0;
      chk("out_valid", out_valid, exp_v);
      chk("vc_ready", vc_ready, (exp_v && out_ready) ? (4'b0001 << m_lock) : 4'b0000);
      chk("err_nohead", err_nohead, m_err);
      if (exp_v) begin
        chk("out_vc", out_vc, m_lock);
        chk("out_data", out_data, vc_data[m_lock*W +: W]);
        chk("out_head", out_head, vc_head[m_lock]);
        chk("out_tail", out_tail, vc_tail[m_lock]);
      end
`ifdef VC_ARB_PKTCNT_EN
      chk("pkt_count", pkt_count, m_pkts & 16'hFFFF);
`endif
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_vc_ready", vc_ready, 4'b0000);
    chk("rst_out_vc", out_vc, 2'd0);
    chk("rst_err", err_nohead, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    step();

    // VC0 3-flit packet and VC2 head compete from pointer 0
    out_ready = 1'b1;
    put(0, 1, 1, 0, 32'h0000_0A00);
    put(2, 1, 1, 1, 32'h0000_0E00);
    settle();
    chk("idle_no_valid", out_valid, 1'b0);
    step();
    chk("rr0_vc", out_vc, 2'd0);
    chk("rr0_data", out_data, 32'h0000_0A00);
    chk("rr0_ready", vc_ready, 4'b0001);
    step();
    put(0, 1, 0, 0, 32'h0000_0A01);
    settle();
    chk("rr0_body_ready", vc_ready, 4'b0001);
    step();
    put(0, 1, 0, 1, 32'h0000_0A02);
    settle();
    chk("rr0_tail", out_tail, 1'b1);
    step();
    put(0, 0, 0, 0, 32'h0);
    settle();
    chk("rr0_done_idle", out_valid, 1'b0);
    step();
    chk("rr1_vc2", out_vc, 2'd2);
    chk("rr1_data", out_data, 32'h0000_0E00);
    step();
    put(2, 0, 0, 0, 32'h0);

    // one-flit packet on VC1
    put(1, 1, 1, 1, 32'hA5A5_A5A5);
    settle();
    step();
    chk("one_valid", out_valid, 1'b1);
    chk("one_vc", out_vc, 2'd1);
    chk("one_data", out_data, 32'hA5A5_A5A5);
    chk("one_ht", {out_head, out_tail}, 2'b11);
    step();
    put(1, 0, 0, 0, 32'h0);
    settle();
    chk("one_idle", out_valid, 1'b0);
    put(0, 1, 1, 1, 32'h0000_C000);
    put(2, 1, 1, 1, 32'h0000_C002);
    settle();
    step();
    chk("ptr2_vc2", out_vc, 2'd2);
    step();
    put(2, 0, 0, 0, 32'h0);
    step();
    chk("ptr3_wrap_vc0", out_vc, 2'd0);
    step();
    put(0, 0, 0, 0, 32'h0);

    // backpressure and bubble on VC1
    put(1, 1, 1, 0, 32'h0000_B000);
    step();
    chk("bp_head", out_data, 32'h0000_B000);
    step();
    put(1, 1, 0, 0, 32'h0000_B001);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_stable", out_data, 32'h0000_B001);
      chk("bp_noready", vc_ready, 4'b0000);
      chk("bp_valid", out_valid, 1'b1);
      step();
    end
    out_ready = 1'b1;
    settle();
    chk("bp_release", vc_ready, 4'b0010);
    step();
    put(1, 0, 0, 0, 32'h0);
    put(3, 1, 1, 1, 32'h0000_3333);
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("bubble_hold", vc_ready, 4'b0000);
      step();
    end
    put(1, 1, 0, 1, 32'h0000_B002);
    step();
    put(1, 0, 0, 0, 32'h0);
    step();
    chk("after_bubble_vc3", out_vc, 2'd3);
    step();
    put(3, 0, 0, 0, 32'h0);

    // headless flit on VC3 while idle
    put(3, 1, 0, 0, 32'hDEAD_0003);
    put(0, 1, 1, 1, 32'h0000_F000);
    settle();
    step();
    chk("nohead_err", err_nohead, 1'b1);
    chk("nohead_vc0", out_vc, 2'd0);
    step();
    put(0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nohead_never", out_valid, 1'b0);
    end
    put(3, 0, 0, 0, 32'h0);
    step();
    chk("nohead_sticky", err_nohead, 1'b1);

    // reset during flit 2 of 4
    put(3, 1, 1, 0, 32'h0000_7000);
    step();
    step();
    put(3, 1, 0, 0, 32'h0000_7001);
    settle();
    chk("mid_data", out_data, 32'h0000_7001);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", vc_ready, 4'b0000);
    chk("arst_vc", out_vc, 2'd0);
    chk("arst_err", err_nohead, 1'b0);
    chk("arst_data", {out_data, out_head, out_tail}, 34'h0);
    put(3, 0, 0, 0, 32'h0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    step();
    put(2, 1, 1, 1, 32'h0000_9002);
    settle();
    step();
    chk("post_rst_vc2", out_vc, 2'd2);
    chk("post_rst_valid", out_valid, 1'b1);
    step();
    put(2, 0, 0, 0, 32'h0);
    step();

`ifdef VC_ARB_PKTCNT_EN
    reset_n = 1'b0;
    #1;
    chk("cnt_rst", pkt_count, 16'h0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    step();
    put(0, 1, 1, 1, 32'h0000_0C0C);
    for (int i = 0; i < 2 * 65535; i++) step();
    chk("cnt_ffff", pkt_count, 16'hFFFF);
    step();
    step();
    put(0, 0, 0, 0, 32'h0);
    chk("cnt_wrap", pkt_count, 16'h0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_sw_arbiter.md
VC_SW_ARBITER -- requirements
Module: vc_sw_arbiter

Interface
REQ-001 SHALL have parameter NUM_VC, default 4, number of input virtual channels (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, flit data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port vc_valid  input  NUM_VC  per-VC head-of-line flit valid.
REQ-006 SHALL have port vc_data  input  NUM_VC*DATA_W  per-VC flit data, VC i at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port vc_head  input  NUM_VC  per-VC head-flit flag.
REQ-008 SHALL have port vc_tail  input  NUM_VC  per-VC tail-flit flag.
REQ-009 SHALL have port vc_ready  output  NUM_VC  per-VC pop strobe; at most one bit set.
REQ-010 SHALL have ports out_data  output  DATA_W, out_head  output  1, out_tail  output  1, out_valid  output  1, all for the switch output flit.
REQ-011 SHALL have port out_ready  input  1  switch accepts flit.
REQ-012 SHALL have port out_vc  output  $clog2(NUM_VC)  VC index of the current flit.
REQ-013 SHALL have port err_nohead  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL implement FSM states IDLE and LOCKED, plus registers lock_vc and rr_ptr.
REQ-015 In IDLE, SHALL treat as eligible only VCs with vc_valid=1 and vc_head=1; SHALL select the first eligible VC at or after rr_ptr in ascending index order with wrap-around; SHALL load lock_vc and go to LOCKED next cycle. Arbitration latency is one cycle.
REQ-016 In IDLE, out_valid and all vc_ready bits SHALL be 0.
REQ-017 In LOCKED, out_valid SHALL equal vc_valid[lock_vc]; out_data, out_head and out_tail SHALL be combinational copies of lock_vc's inputs; out_vc SHALL equal lock_vc.
REQ-018 In LOCKED, vc_ready[lock_vc] SHALL equal out_ready & vc_valid[lock_vc]; all other vc_ready bits SHALL be 0.
REQ-019 Transfer SHALL occur when out_valid & out_ready. Data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 A transfer with out_tail=1 SHALL return the FSM to IDLE and set rr_ptr to (lock_vc+1) mod NUM_VC. A flit with both head and tail set is a one-flit packet.
REQ-021 In LOCKED, a bubble (vc_valid[lock_vc]=0) SHALL hold the lock; other VCs SHALL not be granted until the tail transfers.
REQ-022 In IDLE, if any VC has vc_valid=1 and vc_head=0, err_nohead SHALL set and remain set until reset; that VC SHALL not be granted.
REQ-023 In IDLE with no eligible VC, rr_ptr SHALL hold.

Reset
REQ-024 On reset_n low, asynchronously: FSM=IDLE, lock_vc=0, rr_ptr=0, err_nohead=0, out_valid=0, vc_ready=0, out_vc=0.
REQ-025 Reset mid-packet SHALL abandon the lock; after release, arbitration SHALL restart from VC 0.

Configuration
REQ-026 With macro VC_ARB_PKTCNT_EN defined, SHALL add output pkt_count (16 bits, reset 0) that increments on each tail transfer and wraps from 0xFFFF to 0.
REQ-027 Without VC_ARB_PKTCNT_EN, the pkt_count port and its logic SHALL be absent.

Structure
REQ-028 FSM state encoding (IDLE=0, LOCKED=1) and NUM_VC/DATA_W defaults SHALL live in shared package noc_router_pkg.
REQ-029 The round-robin selector SHALL be a sub-module rr_pick (inputs req, ptr; outputs gnt_idx, gnt_any).

Verification
REQ-030 Verify: VC1 sends a one-flit packet with head=tail=1 and data 0xA5A5A5A5 -> out_valid in cycle 2, out_vc=1, FSM returns to IDLE, rr_ptr=2.
REQ-031 Verify: VC0 and VC2 both present heads, rr_ptr=0 -> VC0's 3-flit packet completes before VC2 is granted; then rr_ptr=1 -> VC2 is granted.
REQ-032 Verify: out_ready held 0 for 3 cycles mid-packet -> out_data stable and vc_ready=0 throughout.
REQ-033 Verify: VC3 has vc_valid=1 and vc_head=0 in IDLE -> err_nohead=1 and VC3 is never granted.
REQ-034 Verify: reset_n pulsed low during flit 2 of 4 -> all outputs 0 immediately; after release, a head on VC2 with rr_ptr=0 is granted.
REQ-035 Verify: with VC_ARB_PKTCNT_EN, 0x10000 tail transfers -> pkt_count=0.
